jt900h_bankfile: RTL and testbench
==================================

Name: jt900h_bankfile

Overview:
Parametrised successor to the CPU general-purpose register file: NBANKS banks of four 32-bit accumulators plus NPTR shared 32-bit pointers.
Provides two combinational read ports and one sized write port.
Adds a bank spill/fill engine that moves a whole bank to or from memory over a req/ack handshake, so the OS or interrupt code can context-switch banks beyond the architectural four.
Sits between the control unit/ALU and the memory controller.

Parameters:
NBANKS, 4, number of accumulator banks; power of two, 2..16
BW, $clog2(NBANKS), bank field width (derived)
NPTR, 4, number of shared pointer registers (XIX, XIY, XIZ, XSP…); power of two, ≤4
SP_RST, 32'h100, reset value of ptr[NPTR-1]
AW, BW+5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset
cen  in  1  clock enable; all state changes require cen=1
rfp  out  BW  current bank pointer
rfp_we  in  1  load rfp from rfp_din
rfp_din  in  BW  new bank pointer
ra_addr  in  AW  read port A address
ra_size  in  2  0=byte, 1=word, 2=long
ra_dout  out  32  read port A data, right-aligned, zero-extended
rb_addr  in  AW  read port B address
rb_size  in  2  read port B size
rb_dout  out  32  read port B data
wr_en  in  1  write strobe
wr_addr  in  AW  write address
wr_size  in  2  write size
wr_data  in  32  write data, right-aligned
xfer_start  in  1  start a bank transfer
xfer_dir  in  1  0=spill (regs→mem), 1=fill (mem→regs)
xfer_bank  in  BW  bank to transfer
xfer_base  in  32  memory base address
busy  out  1  engine active
done  out  1  one-cen pulse at end of transfer
mem_req  out  1  memory request
mem_we  out  1  1=write (spill)
mem_addr  out  32  memory address
mem_dout  out  32  spill data
mem_din  in  32  fill data
mem_ack  in  1  memory acknowledge

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset values:
  - all accumulators 0; ptr[0..NPTR-2]=0; ptr[NPTR-1]=SP_RST
  - rfp=0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_dout=0.
- Address layout: addr={is_ptr, bank[BW-1:0], reg[1:0], lane[1:0]}.
  - is_ptr=1: bank bits ignored; reg selects pointer, taken modulo NPTR.
  - lane selects the byte.
  - Word accesses use lane[1] and ignore lane[0].
  - Long accesses ignore lane.
- Reads are combinational and return contents before any same-cycle write (no bypass). ra_size/rb_size=3 behaves as long.
- Writes take effect on the cen edge.
  - Byte write updates only the selected byte; word write updates only the selected half; long write updates all 32 bits.
  - wr_size=3 is ignored.
- rfp_we loads rfp on the cen edge. rfp is informational only; the caller places the bank in the address.
- Engine FSM states: IDLE, ISSUE, WAIT, DONE. Index i is 0..3.
  - IDLE: xfer_start=1 latches dir, bank and base, sets i=0 and busy=1, then goes to ISSUE. xfer_start while busy is ignored.
  - ISSUE: mem_req=1, mem_we=~dir, mem_addr=base+4*i.
    - Spill: mem_dout=acc[bank][i], sampled here.
    - Go to WAIT.
  - WAIT: mem_req, mem_addr and mem_dout are held stable until a cen cycle with mem_ack=1. On that cycle:
    - Fill writes mem_din into acc[bank][i].
    - mem_req drops.
    - If i=3, go to DONE; else i+1 and go to ISSUE.
    - One idle cycle is required between requests.
  - DONE: done=1 for one cen cycle, busy=0, then IDLE.
  - mem_ack outside WAIT is ignored.
  - Transfer latency with zero-wait ack: 9 cen cycles from start to the done pulse.
- Collisions:
  - A fill write and a port write to the same 32-bit register in the same cycle: the fill wins and the port write is dropped entirely.
  - Writes to other registers proceed.
  - Spill data is the value captured at ISSUE; later port writes do not alter mem_dout.
- Reads of the bank being filled return current contents; there is no interlock. The control unit stalls on busy.
- cen=0: FSM, registers and pulses freeze. done stays asserted until the next cen edge.
- Reset mid-transfer aborts immediately to IDLE; partially filled registers revert to reset values.

Test Plan:
1. After reset: ra_addr={1,..,reg=3,lane=0}, size=2 -> ra_dout=32'h100; any accumulator -> 0; busy=0, mem_req=0.
2. Long-write 32'h11223344 to bank1 reg2; byte-write 8'hAA to lane 2; word-write 16'h5566 to lane 0 -> long read returns 32'h11AA5566; byte read lane 3 returns 32'h11; a read in the same cycle as the write returns the old value.
3. Spill bank2 (regs 1,2,3,4) to base 32'h2000 with ack on the first WAIT cycle -> four writes at 2000/2004/2008/200C carrying 1..4; done pulses 9 cycles after start.
4. Fill bank3 from memory with 3 wait cycles per access; drive cen low for 2 cycles mid-transfer -> request signals stay stable during waits; acc[3][0..3]=mem_din; done pulse is stretched across cen=0.
5. During a fill of bank0 reg1, port long-write 32'hDEAD to bank0 reg1 on the ack cycle and to bank0 reg2 -> reg1 holds the fill data; reg2 holds 32'hDEAD.
6. Assert rst during WAIT of a fill -> mem_req=0 and busy=0 immediately; filled registers are 0; a new xfer_start after reset completes normally.

Source files
------------

// File: rtl/jt900h_bankfile.sv
// Banked accumulator/pointer register file with two combinational read ports,
// one sized write port and a four-word bank spill/fill engine on a req/ack bus.
module jt900h_bankfile #(
    parameter int          NBANKS = 4,
    parameter int          BW     = $clog2(NBANKS),
    parameter int          NPTR   = 4,
    parameter logic [31:0] SP_RST = 32'h100,
    parameter int          AW     = BW + 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cen,
    output logic [BW-1:0] o_rfp,
    input  logic          i_rfp_we,
    input  logic [BW-1:0] i_rfp_din,
    input  logic [AW-1:0] i_ra_addr,
    input  logic [1:0]    i_ra_size,
    output logic [31:0]   o_ra_dout,
    input  logic [AW-1:0] i_rb_addr,
    input  logic [1:0]    i_rb_size,
    output logic [31:0]   o_rb_dout,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [1:0]    i_wr_size,
    input  logic [31:0]   i_wr_data,
    input  logic          i_xfer_start,
    input  logic          i_xfer_dir,
    input  logic [BW-1:0] i_xfer_bank,
    input  logic [31:0]   i_xfer_base,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [31:0]   o_mem_addr,
    output logic [31:0]   o_mem_dout,
    input  logic [31:0]   i_mem_din,
    input  logic          i_mem_ack,
    output logic [1:0]    o_state
);

    // Memory handshake: o_mem_req rises after ISSUE and, together with o_mem_addr,
    // o_mem_we and o_mem_dout, holds until a cen cycle sees i_mem_ack=1; it then
    // drops for at least one cycle before the next request.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_acc [NBANKS][4];
    logic [31:0]   r_ptr [NPTR];
    logic [BW-1:0] r_rfp;
    logic          r_dir;
    logic [BW-1:0] r_bank;
    logic [31:0]   r_base;
    logic [1:0]    r_i;
    logic          r_busy, r_done, r_mem_req, r_mem_we;
    logic [31:0]   r_mem_addr, r_mem_dout;

    logic [31:0]   w_ra_reg, w_rb_reg, w_wr_old, w_wr_new;
    logic          w_wr_ok, w_wr_is_ptr, w_fill_we, w_wr_clash;
    logic [BW-1:0] w_wr_bank;
    logic [1:0]    w_wr_reg, w_wr_lane, w_wr_pidx;

    function automatic logic [1:0] ptr_idx(input logic [1:0] r);
        return r & 2'(NPTR - 1);
    endfunction

    function automatic logic [31:0] lane_rd(input logic [31:0] v, input logic [1:0] size,
                                            input logic [1:0] lane);
        logic [31:0] r;
        case (size)
            2'd0:    r = {24'd0, 8'(v >> {lane, 3'b000})};
            2'd1:    r = {16'd0, 16'(v >> {lane[1], 4'b0000})};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [1:0] size,
                                             input logic [1:0] lane, input logic [31:0] data);
        logic [31:0] mask, shd;
        case (size)
            2'd0: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                shd  = data << {lane, 3'b000};
            end
            2'd1: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                shd  = data << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                shd  = data;
            end
        endcase
        return (old & ~mask) | (shd & mask);
    endfunction

    // Reads see register contents before any same-cycle write.
    always_comb begin
        w_ra_reg = i_ra_addr[AW-1] ? r_ptr[ptr_idx(i_ra_addr[3:2])]
                                   : r_acc[i_ra_addr[AW-2:4]][i_ra_addr[3:2]];
        w_rb_reg = i_rb_addr[AW-1] ? r_ptr[ptr_idx(i_rb_addr[3:2])]
                                   : r_acc[i_rb_addr[AW-2:4]][i_rb_addr[3:2]];
        o_ra_dout = lane_rd(w_ra_reg, i_ra_size, i_ra_addr[1:0]);
        o_rb_dout = lane_rd(w_rb_reg, i_rb_size, i_rb_addr[1:0]);
    end

    always_comb begin
        w_wr_ok     = i_wr_en && (i_wr_size != 2'd3);
        w_wr_is_ptr = i_wr_addr[AW-1];
        w_wr_bank   = i_wr_addr[AW-2:4];
        w_wr_reg    = i_wr_addr[3:2];
        w_wr_lane   = i_wr_addr[1:0];
        w_wr_pidx   = ptr_idx(w_wr_reg);
        w_wr_old    = w_wr_is_ptr ? r_ptr[w_wr_pidx] : r_acc[w_wr_bank][w_wr_reg];
        w_wr_new    = wr_merge(w_wr_old, i_wr_size, w_wr_lane, i_wr_data);
        w_fill_we   = (r_state == S_WAIT) && i_mem_ack && r_dir;
        // A fill landing on the same 32-bit register discards the port write whole.
        w_wr_clash  = w_fill_we && !w_wr_is_ptr && (w_wr_bank == r_bank) && (w_wr_reg == r_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANKS; b++)
                for (int r = 0; r < 4; r++)
                    r_acc[b][r] <= '0;
            for (int p = 0; p < NPTR; p++)
                r_ptr[p] <= (p == NPTR - 1) ? SP_RST : 32'd0;
        end else if (i_cen) begin
            if (w_wr_ok && !w_wr_clash) begin
                if (w_wr_is_ptr)
                    r_ptr[w_wr_pidx] <= w_wr_new;
                else
                    r_acc[w_wr_bank][w_wr_reg] <= w_wr_new;
            end
            if (w_fill_we)
                r_acc[r_bank][r_i] <= i_mem_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rfp <= '0;
        else if (i_cen && i_rfp_we)
            r_rfp <= i_rfp_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else if (i_cen)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_xfer_start) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (i_mem_ack) w_next = (r_i == 2'd3) ? S_DONE : S_ISSUE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir      <= 1'b0;
            r_bank     <= '0;
            r_base     <= '0;
            r_i        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
        end else if (i_cen) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_xfer_start) begin
                    r_dir  <= i_xfer_dir;
                    r_bank <= i_xfer_bank;
                    r_base <= i_xfer_base;
                    r_i    <= '0;
                    r_busy <= 1'b1;
                end
                S_ISSUE: begin
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= ~r_dir;
                    r_mem_addr <= r_base + {28'd0, r_i, 2'b00};
                    if (!r_dir)
                        r_mem_dout <= r_acc[r_bank][r_i];
                end
                S_WAIT: if (i_mem_ack) begin
                    r_mem_req <= 1'b0;
                    if (r_i != 2'd3)
                        r_i <= r_i + 2'd1;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_rfp      = r_rfp;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mem_req  = r_mem_req;
    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_dout = r_mem_dout;
    assign o_state    = r_state;

endmodule

// File: tb/tb_jt900h_bankfile.sv
// Directed plus randomized bench for jt900h_bankfile against a plain-array register model
// and a cycle-level memory responder for bank spill/fill.
module tb_jt900h_bankfile;
    localparam int NB = 4, BW = 2, NPTR = 4, AW = 7;

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    logic          cen, rfp_we, wr_en, xfer_start, xfer_dir, busy, done, mem_req, mem_we, mem_ack;
    logic [BW-1:0] rfp, rfp_din, xfer_bank;
    logic [AW-1:0] ra_addr, rb_addr, wr_addr;
    logic [1:0]    ra_size, rb_size, wr_size, state;
    logic [31:0]   ra_dout, rb_dout, wr_data, xfer_base, mem_addr, mem_dout, mem_din;

    jt900h_bankfile dut (
        .clk(clk), .rst(rst), .i_cen(cen), .o_rfp(rfp), .i_rfp_we(rfp_we), .i_rfp_din(rfp_din),
        .i_ra_addr(ra_addr), .i_ra_size(ra_size), .o_ra_dout(ra_dout),
        .i_rb_addr(rb_addr), .i_rb_size(rb_size), .o_rb_dout(rb_dout),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_size(wr_size), .i_wr_data(wr_data),
        .i_xfer_start(xfer_start), .i_xfer_dir(xfer_dir), .i_xfer_bank(xfer_bank),
        .i_xfer_base(xfer_base), .o_busy(busy), .o_done(done), .o_mem_req(mem_req),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_dout(mem_dout), .i_mem_din(mem_din),
        .i_mem_ack(mem_ack), .o_state(state)
    );

    int checks = 0, errors = 0;
    logic [31:0] m_acc [NB][4];
    logic [31:0] m_ptr [NPTR];
    logic [31:0] exp_q[$];
    int x_wait = 0, x_gap_at = -1, x_stretch = 0, x_coll = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] mk(input int p, input int b, input int r, input int l);
        return {1'(p), 2'(b), 2'(r), 2'(l)};
    endfunction

    task automatic m_reset();
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < 4; r++) m_acc[b][r] = 32'd0;
        for (int p = 0; p < NPTR; p++) m_ptr[p] = (p == NPTR - 1) ? 32'h100 : 32'd0;
    endtask

    function automatic logic [31:0] m_get(input logic [AW-1:0] a);
        return a[AW-1] ? m_ptr[int'(a[3:2]) % NPTR] : m_acc[a[5:4]][a[3:2]];
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] a, input logic [1:0] sz);
        logic [31:0] v;
        int lane;
        v = m_get(a);
        lane = int'(a[1:0]);
        if (sz == 2'd0) return (v >> (8 * lane)) & 32'hFF;
        if (sz == 2'd1) return (v >> (16 * (lane / 2))) & 32'hFFFF;
        return v;
    endfunction

    task automatic m_write(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] v, keep;
        int sh;
        if (sz == 2'd3) return;
        v = m_get(a);
        if (sz == 2'd0) begin
            sh = 8 * int'(a[1:0]);
            keep = ~(32'hFF << sh);
            v = (v & keep) | ((d & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh = 16 * int'(a[1]);
            keep = ~(32'hFFFF << sh);
            v = (v & keep) | ((d & 32'hFFFF) << sh);
        end else v = d;
        if (a[AW-1]) m_ptr[int'(a[3:2]) % NPTR] = v;
        else m_acc[a[5:4]][a[3:2]] = v;
    endtask

    // One port write; also checks that a same-cycle read still returns the old value.
    task automatic port_wr(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_size = sz; wr_data = d;
        ra_addr = a; ra_size = 2'd2;
        #1;
        check("read_before_write", ra_dout, m_get(a));
        step();
        wr_en = 1'b0;
        m_write(a, sz, d);
    endtask

    task automatic check_bank(input int b);
        for (int r = 0; r < 4; r++) begin
            ra_addr = mk(0, b, r, 0); ra_size = 2'd2;
            #1;
            check($sformatf("bank%0d_reg%0d", b, r), ra_dout, m_acc[b][r]);
        end
    endtask

    task automatic run_xfer(input bit dir, input int bank, input logic [31:0] base, output int done_cyc);
        logic [31:0] fdat [4];
        logic [31:0] cur_a, cur_d;
        logic [AW-1:0] pend_a;
        bit req_prev, acked_prev, pend;
        int k, cyc, wcnt;
        for (int i = 0; i < 4; i++) begin
            fdat[i] = $urandom;
            if (!dir) exp_q.push_back(m_acc[bank][i]);
        end
        xfer_dir = dir; xfer_bank = 2'(bank); xfer_base = base; xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        cyc = 0; k = 0; wcnt = 0; req_prev = 0; acked_prev = 0; pend = 0; done_cyc = -1;
        cur_a = 0; cur_d = 0; pend_a = '0;
        while (cyc < 200) begin
            wr_en = 1'b0; mem_ack = 1'b0;
            if (acked_prev) begin
                check("req_idle_after_ack", {31'd0, mem_req}, 32'd0);
                if (pend) m_write(pend_a, 2'd2, 32'hDEAD);
                if (dir && k < 4) m_acc[bank][k] = fdat[k];
                k++; req_prev = 0; acked_prev = 0; pend = 0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            cen = !(x_gap_at >= 0 && cyc >= x_gap_at && cyc < x_gap_at + 2);
            if (mem_req && k < 4) begin
                if (!req_prev) begin
                    check("req_addr", mem_addr, base + 32'(4 * k));
                    check("req_we", {31'd0, mem_we}, {31'd0, ~dir});
                    if (!dir) check("spill_data", mem_dout, exp_q.pop_front());
                    cur_a = mem_addr; cur_d = mem_dout; req_prev = 1; wcnt = 0;
                end else begin
                    check("hold_addr", mem_addr, cur_a);
                    check("hold_dout", mem_dout, cur_d);
                end
                if (wcnt >= x_wait) begin
                    mem_ack = 1'b1; mem_din = fdat[k];
                    if (x_coll != 0 && (k == 1 || k == 3)) begin
                        pend_a = mk(0, bank, (k == 1) ? 1 : 2, 0);
                        wr_en = 1'b1; wr_addr = pend_a; wr_size = 2'd2; wr_data = 32'hDEAD;
                        pend = cen;
                    end
                end
                if (cen) wcnt++;
                acked_prev = mem_ack && cen;
            end
            step();
            cyc++;
        end
        wr_en = 1'b0; mem_ack = 1'b0; cen = 1'b1;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (x_stretch != 0) begin
            cen = 1'b0;
            step(); check("done_held_cen0_a", {31'd0, done}, 32'd1);
            step(); check("done_held_cen0_b", {31'd0, done}, 32'd1);
            cen = 1'b1;
        end
        step();
        check("done_cleared", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dc, bound;
        logic [AW-1:0] a;
        logic [1:0] sz;
        logic [31:0] d;
        rst = 1'b1; cen = 1'b1; rfp_we = 1'b0; rfp_din = '0; wr_en = 1'b0; wr_addr = '0;
        wr_size = 2'd0; wr_data = '0; ra_addr = '0; ra_size = 2'd2; rb_addr = '0; rb_size = 2'd2;
        xfer_start = 1'b0; xfer_dir = 1'b0; xfer_bank = '0; xfer_base = '0;
        mem_ack = 1'b0; mem_din = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        step();

        // Reset state
        ra_addr = mk(1, 0, 3, 0); ra_size = 2'd2; rb_addr = mk(0, 2, 1, 0); rb_size = 2'd2;
        #1;
        check("rst_sp", ra_dout, 32'h100);
        check("rst_acc", rb_dout, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rfp", {30'd0, rfp}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);

        // Sized writes and reads
        port_wr(mk(0, 1, 2, 0), 2'd2, 32'h11223344);
        port_wr(mk(0, 1, 2, 2), 2'd0, 32'h000000AA);
        port_wr(mk(0, 1, 2, 0), 2'd1, 32'h00005566);
        ra_addr = mk(0, 1, 2, 0); ra_size = 2'd2; rb_addr = mk(0, 1, 2, 3); rb_size = 2'd0;
        #1;
        check("sized_long", ra_dout, 32'h11AA5566);
        check("sized_byte3", rb_dout, 32'h00000011);
        rb_addr = mk(0, 1, 2, 3); rb_size = 2'd1;
        #1;
        check("sized_word_hi", rb_dout, 32'h000011AA);
        port_wr(mk(0, 1, 2, 0), 2'd3, 32'hFFFFFFFF);
        ra_addr = mk(0, 1, 2, 0); ra_size = 2'd3;
        #1;
        check("size3_ignored", ra_dout, 32'h11AA5566);

        // Clock enable freezes writes and rfp
        rfp_we = 1'b1; rfp_din = 2'd2;
        step();
        check("rfp_load", {30'd0, rfp}, 32'd2);
        cen = 1'b0; rfp_din = 2'd1; wr_en = 1'b1; wr_addr = mk(0, 0, 0, 0); wr_size = 2'd2;
        wr_data = 32'h12345678;
        step();
        check("rfp_frozen", {30'd0, rfp}, 32'd2);
        wr_en = 1'b0; rfp_we = 1'b0; cen = 1'b1;
        ra_addr = mk(0, 0, 0, 0);
        #1;
        check("write_frozen", ra_dout, 32'd0);

        // Spill bank2 with immediate ack
        for (int r = 0; r < 4; r++) port_wr(mk(0, 2, r, 0), 2'd2, 32'(r + 1));
        x_wait = 0; x_gap_at = -1; x_stretch = 0; x_coll = 0;
        run_xfer(1'b0, 2, 32'h2000, dc);
        check("spill_latency", 32'(dc), 32'd9);

        // Fill bank3 with waits and a cen gap; done stretched by cen=0
        x_wait = 3; x_gap_at = 5; x_stretch = 1;
        run_xfer(1'b1, 3, 32'h3000, dc);
        check("fill_latency", 32'(dc), 32'd23);
        check_bank(3);

        // Fill bank0 with port writes colliding on reg1 and hitting reg2
        x_wait = 0; x_gap_at = -1; x_stretch = 0; x_coll = 1;
        run_xfer(1'b1, 0, 32'h4000, dc);
        x_coll = 0;
        check_bank(0);
        ra_addr = mk(0, 0, 2, 0); ra_size = 2'd2;
        #1;
        check("coll_reg2_dead", ra_dout, 32'hDEAD);

        // Reset during a fill
        xfer_dir = 1'b1; xfer_bank = 2'd1; xfer_base = 32'h5000; xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        bound = 0;
        while (!mem_req && bound < 20) begin step(); bound++; end
        check("rst_test_req1", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_din = 32'hCAFE0001;
        step();
        mem_ack = 1'b0;
        m_acc[1][0] = 32'hCAFE0001;
        ra_addr = mk(0, 1, 0, 0); ra_size = 2'd2;
        #1;
        check("rst_test_filled", ra_dout, 32'hCAFE0001);
        bound = 0;
        while (!mem_req && bound < 20) begin step(); bound++; end
        check("rst_test_req2", {31'd0, mem_req}, 32'd1);
        step();
        #2; rst = 1'b1; #1;
        m_reset();
        check("abort_req", {31'd0, mem_req}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_reg0", ra_dout, 32'd0);
        step();
        rst = 1'b0;
        step();
        run_xfer(1'b1, 1, 32'h6000, dc);
        check("post_rst_latency", 32'(dc), 32'd9);
        check_bank(1);

        // Random sized writes and reads against the model
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom); sz = 2'($urandom_range(0, 3)); d = $urandom;
            port_wr(a, sz, d);
            rb_addr = AW'($urandom); rb_size = 2'($urandom_range(0, 3));
            #1;
            check("rand_read", rb_dout, m_read(rb_addr, rb_size));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
